// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: funct3 codes, FSM states,
// lane geometry and the access legality check.
package lsu_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 8;
  localparam int unsigned WORD_W = LANES * LANE_W;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE,
    RMW_WR
  } lsu_state_t;

  // Misaligned address, unused funct3, or an unsigned-load code on a store.
  function automatic logic access_err(input logic store, input logic [2:0] f3,
                                      input logic [1:0] off);
    case (f3)
      F3_B:    access_err = 1'b0;
      F3_H:    access_err = off[0];
      F3_W:    access_err = |off;
      F3_BU:   access_err = store;
      F3_HU:   access_err = store | off[0];
      default: access_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: load extract with sign/zero extension, and sub-word
// store merge into an existing memory word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        off_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] load_c_o,
  output logic [WORD_W-1:0] merge_c_o
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c    = word_i[{off_i, 3'b000} +: 8];
    half_c    = off_i[1] ? word_i[31:16] : word_i[15:0];
    load_c_o  = word_i;
    merge_c_o = word_i;
    case (funct3_i)
      F3_B:    load_c_o = {{24{byte_c[7]}}, byte_c};
      F3_BU:   load_c_o = {24'b0, byte_c};
      F3_H:    load_c_o = {{16{half_c[15]}}, half_c};
      F3_HU:   load_c_o = {16'b0, half_c};
      default: load_c_o = word_i;
    endcase
    case (funct3_i)
      F3_B: merge_c_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      F3_H: begin
        if (off_i[1]) merge_c_o[31:16] = wdata_i[15:0];
        else          merge_c_o[15:0]  = wdata_i[15:0];
      end
      default: merge_c_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator for a word-addressed data memory; sub-word
// stores are done as a read-modify-write over two cycles.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned M = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_store,
  input  logic [2:0]   req_funct3,
  input  logic [N-1:0] req_addr,
  input  logic [M-1:0] req_wdata,
  output logic         resp_valid,
  output logic [M-1:0] resp_rdata,
  output logic         resp_err,
  output logic         mem_we,
  output logic [N-1:0] mem_adr,
  output logic [M-1:0] mem_din,
  input  logic [M-1:0] mem_dout
);

  if (M != WORD_W) begin : g_bad_width
    $error("load_store_unit: M must be 32");
  end

  lsu_state_t   state_q, state_d;
  logic [M-1:0] merge_q, merge_d;
  logic [M-1:0] rdata_q, rdata_d;
  logic [N-1:0] idx_q, idx_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;

  logic         err_c;
  logic [N-1:0] word_idx_c;
  logic [M-1:0] load_c, merge_c;

  assign err_c      = access_err(req_store, req_funct3, req_addr[1:0]);
  assign word_idx_c = {2'b00, req_addr[N-1:2]};

  lsu_lane_align u_align (
    .funct3_i  (req_funct3),
    .off_i     (req_addr[1:0]),
    .word_i    (mem_dout),
    .wdata_i   (req_wdata),
    .load_c_o  (load_c),
    .merge_c_o (merge_c)
  );

  // Next-state and memory-side drive; mem_we is qualified by reset_n so a
  // write can never escape while reset is held.
  always_comb begin
    state_d   = state_q;
    merge_d   = merge_q;
    idx_d     = idx_q;
    rdata_d   = '0;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    req_ready = 1'b0;
    mem_we    = 1'b0;
    mem_adr   = word_idx_c;
    mem_din   = req_wdata;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (err_c) begin
            valid_d = 1'b1;
            err_d   = 1'b1;
          end else if (!req_store) begin
            valid_d = 1'b1;
            rdata_d = load_c;
          end else if (req_funct3 == F3_W) begin
            valid_d = 1'b1;
            mem_we  = reset_n;
          end else begin
            merge_d = merge_c;
            idx_d   = word_idx_c;
            state_d = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        mem_we  = reset_n;
        mem_adr = idx_q;
        mem_din = merge_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      merge_q <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small behavioural word memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int unsigned N = 32;
  localparam int unsigned M = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req_valid, req_ready, req_store;
  logic [2:0]   req_funct3;
  logic [N-1:0] req_addr;
  logic [M-1:0] req_wdata;
  logic         resp_valid, resp_err;
  logic [M-1:0] resp_rdata;
  logic         mem_we;
  logic [N-1:0] mem_adr;
  logic [M-1:0] mem_din, mem_dout;

  logic         poke_en;
  logic [3:0]   poke_adr;
  logic [31:0]  poke_dat;
  logic [31:0]  mem [16];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.N(N), .M(M)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_adr    (mem_adr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  assign mem_dout = mem[mem_adr[3:0]];

  always @(posedge clk) begin
    if (poke_en)     mem[poke_adr] <= poke_dat;
    else if (mem_we) mem[mem_adr[3:0]] <= mem_din;
  end

  typedef struct {
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    req_valid  = v;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
  endtask

  task automatic poke(input logic [3:0] a, input logic [31:0] d);
    poke_adr = a;
    poke_dat = d;
    poke_en  = 1'b1;
    @(negedge clk);
    poke_en  = 1'b0;
  endtask

  initial begin
    logic bad;
    poke_en  = 1'b0;
    poke_adr = '0;
    poke_dat = '0;
    vecs[0]  = '{1'b0, F3_B,   32'h08, 32'h0,        1'b0, 1'b0, 32'hFFFFFFD4};
    vecs[1]  = '{1'b0, F3_BU,  32'h08, 32'h0,        1'b0, 1'b0, 32'h000000D4};
    vecs[2]  = '{1'b0, F3_H,   32'h0A, 32'h0,        1'b0, 1'b0, 32'hFFFFA1B2};
    vecs[3]  = '{1'b0, F3_HU,  32'h0A, 32'h0,        1'b0, 1'b0, 32'h0000A1B2};
    vecs[4]  = '{1'b0, F3_W,   32'h08, 32'h0,        1'b0, 1'b0, 32'hA1B2C3D4};
    vecs[5]  = '{1'b0, F3_B,   32'h0B, 32'h0,        1'b0, 1'b0, 32'hFFFFFFA1};
    vecs[6]  = '{1'b0, F3_BU,  32'h09, 32'h0,        1'b0, 1'b0, 32'h000000C3};
    vecs[7]  = '{1'b0, F3_H,   32'h08, 32'h0,        1'b0, 1'b0, 32'hFFFFC3D4};
    vecs[8]  = '{1'b0, F3_W,   32'h06, 32'h0,        1'b0, 1'b1, 32'h0};
    vecs[9]  = '{1'b1, F3_H,   32'h0B, 32'hDEAD,     1'b0, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 3'b011, 32'h08, 32'h0,        1'b0, 1'b1, 32'h0};
    vecs[11] = '{1'b1, F3_BU,  32'h08, 32'h77,       1'b0, 1'b1, 32'h0};
    vecs[12] = '{1'b1, F3_W,   32'h10, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0};
    vecs[13] = '{1'b0, F3_W,   32'h10, 32'h0,        1'b0, 1'b0, 32'hCAFEF00D};
    vecs[14] = '{1'b0, F3_H,   32'h12, 32'h0,        1'b0, 1'b0, 32'hFFFFCAFE};

    // Reset with a live SW request on the inputs: nothing may reach memory.
    reset_n = 1'b0;
    drive(1'b1, 1'b1, F3_W, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
    poke(4'd2, 32'hA1B2C3D4);
    poke(4'd3, 32'h0);
    poke(4'd4, 32'h0);
    reset_n = 1'b1;

    // Back-to-back single-cycle requests from the table.
    for (int i = 0; i <= NV; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("v%0d_resp_valid", i - 1), 32'(resp_valid), 32'd1);
        chk($sformatf("v%0d_err", i - 1), 32'(resp_err), 32'(vecs[i-1].err));
        chk($sformatf("v%0d_rdata", i - 1), resp_rdata, vecs[i-1].rdata);
      end
      if (i < NV) begin
        drive(1'b1, vecs[i].store, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
        #1;
        chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'd1);
        chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].we));
        chk($sformatf("v%0d_mem_adr", i), mem_adr, vecs[i].addr >> 2);
        if (vecs[i].we) chk($sformatf("v%0d_mem_din", i), mem_din, vecs[i].wdata);
      end else begin
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
      end
    end

    // SB 0x09 then LW 0x08; an unaccepted LW 0x0C is held on the bus at T+1.
    @(negedge clk);
    drive(1'b1, 1'b1, F3_B, 32'h09, 32'h00000055);
    #1;
    chk("sb_t0_ready", 32'(req_ready), 32'd1);
    chk("sb_t0_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk("sb_t1_resp_valid", 32'(resp_valid), 32'd0);
    drive(1'b1, 1'b0, F3_W, 32'h0C, 32'h0);
    #1;
    chk("sb_t1_ready", 32'(req_ready), 32'd0);
    chk("sb_t1_we", 32'(mem_we), 32'd1);
    chk("sb_t1_adr", mem_adr, 32'd2);
    chk("sb_t1_din", mem_din, 32'hA1B255D4);
    @(negedge clk);
    chk("sb_t2_resp_valid", 32'(resp_valid), 32'd1);
    chk("sb_t2_err", 32'(resp_err), 32'd0);
    chk("sb_t2_rdata", resp_rdata, 32'h0);
    drive(1'b1, 1'b0, F3_W, 32'h08, 32'h0);
    #1;
    chk("sb_t2_ready", 32'(req_ready), 32'd1);
    chk("sb_t2_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk("lw_after_sb_valid", 32'(resp_valid), 32'd1);
    chk("lw_after_sb_rdata", resp_rdata, 32'hA1B255D4);
    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);

    // SH 0x0A with SW 0x0C waiting; SW must be taken exactly at SH's T+2.
    poke(4'd2, 32'hA1B2C3D4);
    drive(1'b1, 1'b1, F3_H, 32'h0A, 32'h0000BEEF);
    #1;
    chk("sh_t0_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("sh_t1_resp_valid", 32'(resp_valid), 32'd0);
    drive(1'b1, 1'b1, F3_W, 32'h0C, 32'h12345678);
    #1;
    chk("sh_t1_ready", 32'(req_ready), 32'd0);
    chk("sh_t1_we", 32'(mem_we), 32'd1);
    chk("sh_t1_adr", mem_adr, 32'd2);
    chk("sh_t1_din", mem_din, 32'hBEEFC3D4);
    @(negedge clk);
    chk("sh_t2_resp_valid", 32'(resp_valid), 32'd1);
    #1;
    chk("sw_t2_ready", 32'(req_ready), 32'd1);
    chk("sw_t2_we", 32'(mem_we), 32'd1);
    chk("sw_t2_adr", mem_adr, 32'd3);
    chk("sw_t2_din", mem_din, 32'h12345678);
    @(negedge clk);
    chk("sw_t3_resp_valid", 32'(resp_valid), 32'd1);
    chk("sw_t3_err", 32'(resp_err), 32'd0);
    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
    chk("word2_after_sh", mem[2], 32'hBEEFC3D4);
    chk("word3_after_sw", mem[3], 32'h12345678);

    // Reset during RMW_WR of SB 0x08: the write must be abandoned.
    poke(4'd2, 32'hA1B2C3D4);
    drive(1'b1, 1'b1, F3_B, 32'h08, 32'h000000FF);
    #1;
    chk("rmwrst_t0_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
    #1;
    chk("rmwrst_t1_we_before", 32'(mem_we), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rmwrst_we", 32'(mem_we), 32'd0);
    chk("rmwrst_ready", 32'(req_ready), 32'd1);
    chk("rmwrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rmwrst_rdata", resp_rdata, 32'h0);
    chk("rmwrst_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid || mem_we) bad = 1'b1;
    end
    chk("rmwrst_no_resp_after", 32'(bad), 32'd0);
    chk("rmwrst_word2", mem[2], 32'hA1B2C3D4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

MEM-stage initiator that drives the word-addressed data memory on behalf of the pipeline. Accepts one load or store per handshake, converts the byte address into a word index, performs sign/zero extension for LB/LH/LBU/LHU, and implements SB/SH as a two-cycle read-modify-write, because the memory only supports whole-word writes. Returns a registered response and flags misaligned accesses without touching memory.

## Interface
Parameters:
- N, 32, byte-address width from the pipeline; also the memory index width.
- M, 32, data width; fixed at 32 (4 byte lanes), any other value is a elaboration error.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  pipeline presents a request.
- req_ready  out  1  unit can accept this cycle (high only in IDLE).
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101; others are illegal.
- req_addr  in  N  byte address.
- req_wdata  in  M  store data (low byte/half used for SB/SH).
- resp_valid  out  1  one-cycle pulse, request completed.
- resp_rdata  out  M  extended load data (0 for stores/errors).
- resp_err  out  1  misaligned or illegal funct3; valid with resp_valid.
- mem_we  out  1  word write enable to memory.
- mem_adr  out  N  word index = {2'b00, req_addr[N-1:2]} (held address during RMW).
- mem_din  out  M  word write data.
- mem_dout  in  M  combinational read data of mem[mem_adr].

## Operation
- States: IDLE, RMW_WR. Accept = req_valid & req_ready.
- Checks at accept: halfword needs addr[0]=0; word needs addr[1:0]=00; funct3 011/110/111 illegal; LBU/LHU-coded stores (100/101) illegal. Error → no mem_we, resp_err=1, resp_rdata=0.
- Load: mem_adr driven from req_addr; lane chosen by addr[1:0] (byte) or addr[1] (half); sign-extend for LB/LH, zero-extend for LBU/LHU; result registered into resp_rdata.
- SW: mem_we=1, mem_din=req_wdata combinationally in the accept cycle.
- SB/SH: accept cycle reads mem_dout, registers merged word (new byte/half into selected lane, other lanes unchanged) plus word index; go to RMW_WR. In RMW_WR: mem_we=1, mem_din=merged word, mem_adr=held index; return to IDLE.
- mem_we is never asserted outside those two cases and is 0 whenever reset_n=0.
- Unaccepted inputs are ignored; mem_adr follows req_addr in IDLE even without req_valid (reads are harmless).

## Timing
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, merge/index registers=0; mem_we=0.
- Load, SW, error: accept at cycle T, resp_valid at T+1 (latency 1); new request may be accepted at T+1 (back-to-back, one per cycle).
- SB/SH: accept at T, mem_we at T+1 (req_ready=0), resp_valid at T+2, next accept at T+2.
- resp_valid and a new accept may coincide; resp fields belong to the older request.
- Load following a sub-word store to the same word at T+2 sees the merged value (write landed at T+1 edge).
- Reset asserted in RMW_WR: write abandoned (mem_we drops asynchronously), no resp_valid, memory word unchanged.
- Address wrap: word index truncates to N bits; no range check (memory decodes).

## Structure
- Package lsu_pkg: funct3 localparams/enum (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum lsu_state_t {IDLE, RMW_WR}, lane-count constant.
- Sub-module lsu_lane_align (combinational): load extract/extend and store merge given funct3, addr[1:0], word, wdata. FSM and registers stay in load_store_unit.

## Test plan
Memory preloaded with word index 2 (byte addr 0x08) = 0xA1B2C3D4.
- LB 0x08 → resp_rdata 0xFFFFFFD4 at T+1; LBU 0x08 → 0x000000D4; LH 0x0A → 0xFFFFA1B2; LHU 0x0A → 0x0000A1B2; LW 0x08 → 0xA1B2C3D4, resp_err=0 for all.
- SB 0x09 data 0x00000055 → req_ready=0 at T+1, mem_we=1 only at T+1 with mem_adr=2, mem_din=0xA1B255D4; resp_valid at T+2; following LW 0x08 → 0xA1B255D4.
- SH 0x0A data 0x0000BEEF then SW 0x0C data 0x12345678 back-to-back → word2=0xBEEFC3D4, word3=0x12345678, SW accepted exactly at SH's T+2.
- LW 0x06, SH 0x0B, funct3=011 → resp_err=1, resp_rdata=0, mem_we never asserted, latency 1.
- Assert reset_n=0 during RMW_WR of SB 0x08 data 0xFF → no write, word2 stays 0xA1B2C3D4, all outputs at reset values, no resp_valid after release.
